// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_sync write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let an owner push up to BURST_LEN words per grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MEMORY_WIDTH = 4,
    parameter int ID_W         = 2,
    parameter int BURST_LEN    = 4,
    parameter int CNT_W        = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*MEMORY_WIDTH-1:0] din,
    input  logic                            full,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            w_en,
    output logic [MEMORY_WIDTH-1:0]         wdata,
    output logic [ID_W-1:0]                 owner,
    output logic                            busy
);

    if (NUM_REQ < 2 || (1 << ID_W) < NUM_REQ || BURST_LEN < 1 || (1 << CNT_W) < BURST_LEN) begin : g_bad_cfg
        $error("fifo_wr_arbiter: inconsistent parameters");
    end

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         owner_q, owner_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic [ID_W-1:0]         pick_id;
    logic [ID_W-1:0]         cand_id;
    int                      cand;
    logic [MEMORY_WIDTH-1:0] din_arr [NUM_REQ];
`ifdef FIFO_ARB_BURST_EN
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign din_arr[g] = din[g*MEMORY_WIDTH +: MEMORY_WIDTH];
    end

    // Scan from farthest to nearest so the requester closest after last wins.
    always_comb begin
        pick_id = '0;
        cand    = 0;
        cand_id = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand    = (int'(last_q) + i) % NUM_REQ;
            cand_id = ID_W'(cand);
            if (req[cand_id]) begin
                pick_id = cand_id;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
`ifdef FIFO_ARB_BURST_EN
        cnt_d   = cnt_q;
`endif
        gnt     = '0;
        wdata   = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = pick_id;
`ifdef FIFO_ARB_BURST_EN
                    cnt_d   = '0;
`endif
                    state_d = OWN;
                end
            end
            OWN: begin
                // A dropped request releases even while the FIFO is full.
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (!full) begin
                    gnt[owner_q] = 1'b1;
                    wdata        = din_arr[owner_q];
`ifdef FIFO_ARB_BURST_EN
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = IDLE;
                    last_d  = owner_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef FIFO_ARB_BURST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign w_en  = |gnt;
    assign owner = owner_q;
    assign busy  = (state_q == OWN);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `fifo_sync` write port among `NUM_REQ` producers. It grants one producer at a time, lets it push up to `BURST_LEN` words, and drives `w_en`/`wdata` into the FIFO. It honours `full` so no write is ever issued to a full FIFO. It sits directly in front of `fifo_sync`; the read side of the FIFO is untouched.

## Interface
- `NUM_REQ`, 4: number of producers (≥2).
- `MEMORY_WIDTH`, 4: data width; must match `fifo_sync`.
- `ID_W`, 2: width of the owner index; must satisfy `ID_W = clog2(NUM_REQ)`.
- `BURST_LEN`, 4: maximum accepted words per grant (≥1).
- `CNT_W`, 2: burst counter width; `2^CNT_W ≥ BURST_LEN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-producer request; held high while the producer has a word on its slice of `din`.
- `din`  in  NUM_REQ*MEMORY_WIDTH  flattened producer data; slice i is `din[i*MEMORY_WIDTH +: MEMORY_WIDTH]`.
- `full`  in  1  from `fifo_sync`.
- `gnt`  out  NUM_REQ  one-hot accept strobe; `gnt[i]` high means producer i's word is consumed at this edge.
- `w_en`  out  1  to `fifo_sync`.
- `wdata`  out  MEMORY_WIDTH  to `fifo_sync`.
- `owner`  out  ID_W  index of the current owner; meaningful only when `busy` is high.
- `busy`  out  1  high in state OWN.

## Operation
- Registered state: `state` (IDLE/OWN), `owner`, `last` (ID_W), `cnt` (CNT_W).
- Reset values: `state`=IDLE, `owner`=0, `last`=NUM_REQ-1 (so requester 0 wins first), `cnt`=0.
- Reset values of outputs: `gnt`=0, `w_en`=0, `wdata`=0, `busy`=0.
- IDLE:
  - No grants are issued.
  - If `|req`, select the first requester with `req` high, searching (last+1), (last+2), … modulo NUM_REQ.
  - Load `owner`, clear `cnt`, and go to OWN.
  - If no request, stay in IDLE.
- OWN:
  - `gnt[owner] = req[owner] & ~full`; all other `gnt` bits are 0.
  - `w_en = |gnt`.
  - `wdata` = din slice of `owner` when `w_en` is high, else 0.
- On an accepted word:
  - `cnt` increments.
  - If `cnt == BURST_LEN-1` before the increment, go to IDLE, set `last`=`owner`, clear `cnt`.
- If `req[owner]` is low in OWN, release immediately: go to IDLE and set `last`=`owner`. There is no grant that cycle.
- If `full` is high and `req[owner]` is high, hold OWN. `cnt` is frozen and no grant is issued; ownership is kept until FIFO space returns.
- Simultaneous events: requests arriving during OWN are ignored until the next IDLE.
- `full` and the release conditions are evaluated in the same cycle. When `full` is high and the owner drops `req`, release wins.
- Reset mid-burst: everything returns to reset values asynchronously. A partially sent burst is not resumed, and the FIFO contents are unaffected.
- `cnt` never exceeds BURST_LEN-1, so there is no wrap-around ambiguity.

## Timing
- Arbitration latency: `req` is sampled high in IDLE at edge N. The block is in OWN after edge N, and the first `gnt` is high in cycle N+1 if `full` is low.
- `gnt`, `w_en` and `wdata` are combinational from registered state, `req`, `din` and `full`. The write lands in the FIFO at the same edge the producer sees `gnt`.
- Steady-state throughput is one word per clock within a burst.
- There is one IDLE bubble cycle between consecutive owners.
- Producers must present the next word on `din` in the cycle after each `gnt`.

## Configuration
- `FIFO_ARB_BURST_EN` defined: burst behaviour is exactly as above, using `BURST_LEN`.
- `FIFO_ARB_BURST_EN` undefined:
  - The effective burst length is 1, and `cnt` logic is compiled out.
  - Every accepted word returns the block to IDLE and advances `last`, giving strict per-word round-robin with a bubble between words.

## Test plan
- Reset: hold `rst`=1 while `req`=4'b1111 → `gnt`=0, `w_en`=0, `wdata`=0, `busy`=0. Release reset → first owner is 0.
- Single producer with the macro on: `req`=4'b0100, din slice 2 = 1,2,3,4,5 → `owner`=2, and four writes 1–4 on consecutive cycles. Then one IDLE cycle, and owner 2 is regranted for word 5.
- Fairness with the macro on: `req`=4'b1111 continuously, FIFO drained every cycle → the owner sequence is 0,1,2,3,0, and each owner gets exactly 4 `gnt` pulses.
- Full backpressure: a depth-4 FIFO with `r_en`=0 and producer 1 sending 1,2,3,4,5 → four writes, then `full`=1. `gnt`, `w_en` stay 0 while `busy`=1 and `owner`=1. Pulse `r_en` one cycle → exactly one more write, value 5.
- Early release and reset: producer 3 drops `req` after 2 words → IDLE next cycle with `last`=3, and a waiting producer 0 wins. Assert `rst` mid-burst → outputs are 0 immediately, and the next owner after reset is 0.
- Macro off: `req`=4'b0011 → owners alternate 0,1,0,1 with exactly one `gnt` per grant.
